// File: rtl/alu_rs_pkg.sv
// Shared types and constants for the ALU reservation station.
// Holds the entry layout, the work_type encodings and the CDB tag-match helper.
package alu_rs_pkg;
  localparam int RS_SIZE_DEF  = 8;
  localparam int RS_IDX_W_DEF = 3;
  localparam int ROB_W        = 4;

  // work_type: [4]=branch, [3]=sub/sra variant, [2:0]=op
  localparam logic [4:0] WT_ADD = 5'b00000;
  localparam logic [4:0] WT_SUB = 5'b01000;
  localparam logic [4:0] WT_AND = 5'b00111;

  typedef struct packed {
    logic             busy;
    logic [4:0]       typ;
    logic [31:0]      vj;
    logic [ROB_W-1:0] qj;
    logic             j_rdy;
    logic [31:0]      vk;
    logic [ROB_W-1:0] qk;
    logic             k_rdy;
    logic [ROB_W-1:0] rob_id;
  } rs_ent_t;

  function automatic logic cdb_hit(input logic vld, input logic [ROB_W-1:0] q,
                                   input logic [ROB_W-1:0] id);
    return vld && (q == id);
  endfunction
endpackage

// File: rtl/alu_rs_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest asserted request plus an any flag.
module alu_rs_prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     i_req,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = IDX_W'(i);
        o_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers ops until both operands are known, snoops the ALU
// and LSB result buses, and dispatches the lowest-index ready op per cycle.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE  = RS_SIZE_DEF,
  parameter int RS_IDX_W = RS_IDX_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rdy,
  input  logic             i_clear,
  input  logic             i_issue_valid,
  input  logic [4:0]       i_issue_type,
  input  logic [31:0]      i_issue_vj,
  input  logic [ROB_W-1:0] i_issue_qj,
  input  logic             i_issue_j_rdy,
  input  logic [31:0]      i_issue_vk,
  input  logic [ROB_W-1:0] i_issue_qk,
  input  logic             i_issue_k_rdy,
  input  logic [ROB_W-1:0] i_issue_rob_id,
  output logic             o_full,
  input  logic             i_alu_cdb_valid,
  input  logic [ROB_W-1:0] i_alu_cdb_id,
  input  logic [31:0]      i_alu_cdb_value,
  input  logic             i_lsb_cdb_valid,
  input  logic [ROB_W-1:0] i_lsb_cdb_id,
  input  logic [31:0]      i_lsb_cdb_value,
  output logic             o_out_valid,
  output logic [4:0]       o_out_type,
  output logic [31:0]      o_out_r1,
  output logic [31:0]      o_out_r2,
  output logic [ROB_W-1:0] o_out_rob_id
);
  rs_ent_t [RS_SIZE-1:0] r_ent;

  logic [RS_SIZE-1:0]        w_busy, w_ready;
  logic [RS_SIZE-1:0]        w_j_hit, w_k_hit, w_j_alu, w_k_alu;
  logic [RS_SIZE-1:0][31:0]  w_j_val, w_k_val;
  logic [RS_IDX_W-1:0]       w_free_idx, w_rdy_idx;
  logic                      w_any_free, w_any_rdy;
  rs_ent_t                   w_new;

  for (genvar g = 0; g < RS_SIZE; g++) begin : g_ent
    assign w_busy[g]  = r_ent[g].busy;
    assign w_ready[g] = r_ent[g].busy & r_ent[g].j_rdy & r_ent[g].k_rdy;
    assign w_j_alu[g] = cdb_hit(i_alu_cdb_valid, r_ent[g].qj, i_alu_cdb_id);
    assign w_k_alu[g] = cdb_hit(i_alu_cdb_valid, r_ent[g].qk, i_alu_cdb_id);
    assign w_j_hit[g] = r_ent[g].busy & ~r_ent[g].j_rdy &
                        (w_j_alu[g] | cdb_hit(i_lsb_cdb_valid, r_ent[g].qj, i_lsb_cdb_id));
    assign w_k_hit[g] = r_ent[g].busy & ~r_ent[g].k_rdy &
                        (w_k_alu[g] | cdb_hit(i_lsb_cdb_valid, r_ent[g].qk, i_lsb_cdb_id));
    assign w_j_val[g] = w_j_alu[g] ? i_alu_cdb_value : i_lsb_cdb_value;
    assign w_k_val[g] = w_k_alu[g] ? i_alu_cdb_value : i_lsb_cdb_value;
  end

  assign o_full = &w_busy;

  alu_rs_prio_enc #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_enc (
    .i_req(~w_busy), .o_idx(w_free_idx), .o_any(w_any_free));

  alu_rs_prio_enc #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_rdy_enc (
    .i_req(w_ready), .o_idx(w_rdy_idx), .o_any(w_any_rdy));

  // Same-cycle forwarding so an op whose producer broadcasts now never waits on a tag
  always_comb begin
    w_new        = '0;
    w_new.busy   = 1'b1;
    w_new.typ    = i_issue_type;
    w_new.qj     = i_issue_qj;
    w_new.qk     = i_issue_qk;
    w_new.rob_id = i_issue_rob_id;
    w_new.vj     = i_issue_vj;
    w_new.j_rdy  = i_issue_j_rdy;
    w_new.vk     = i_issue_vk;
    w_new.k_rdy  = i_issue_k_rdy;
    if (!i_issue_j_rdy) begin
      if (cdb_hit(i_alu_cdb_valid, i_issue_qj, i_alu_cdb_id)) begin
        w_new.vj = i_alu_cdb_value; w_new.j_rdy = 1'b1;
      end else if (cdb_hit(i_lsb_cdb_valid, i_issue_qj, i_lsb_cdb_id)) begin
        w_new.vj = i_lsb_cdb_value; w_new.j_rdy = 1'b1;
      end
    end
    if (!i_issue_k_rdy) begin
      if (cdb_hit(i_alu_cdb_valid, i_issue_qk, i_alu_cdb_id)) begin
        w_new.vk = i_alu_cdb_value; w_new.k_rdy = 1'b1;
      end else if (cdb_hit(i_lsb_cdb_valid, i_issue_qk, i_lsb_cdb_id)) begin
        w_new.vk = i_lsb_cdb_value; w_new.k_rdy = 1'b1;
      end
    end
  end

  // Issue slot (free), dispatch slot (ready) and snooped slots (waiting) never coincide
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ent        <= '0;
      o_out_valid  <= 1'b0;
      o_out_type   <= '0;
      o_out_r1     <= '0;
      o_out_r2     <= '0;
      o_out_rob_id <= '0;
    end else if (i_rdy) begin
      if (i_clear) begin
        for (int i = 0; i < RS_SIZE; i++) r_ent[i].busy <= 1'b0;
        o_out_valid <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (w_j_hit[i]) begin
            r_ent[i].vj <= w_j_val[i]; r_ent[i].j_rdy <= 1'b1;
          end
          if (w_k_hit[i]) begin
            r_ent[i].vk <= w_k_val[i]; r_ent[i].k_rdy <= 1'b1;
          end
        end
        o_out_valid <= w_any_rdy;
        if (w_any_rdy) begin
          o_out_type          <= r_ent[w_rdy_idx].typ;
          o_out_r1            <= r_ent[w_rdy_idx].vj;
          o_out_r2            <= r_ent[w_rdy_idx].vk;
          o_out_rob_id        <= r_ent[w_rdy_idx].rob_id;
          r_ent[w_rdy_idx].busy <= 1'b0;
        end
        if (i_issue_valid && w_any_free) r_ent[w_free_idx] <= w_new;
      end
    end
  end
endmodule
